// File: rtl/prio_arb_pkg.sv
// Shared types and mode constants for the N-way priority arbiter.
package prio_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned ARB_MODE_FIXED = 0;
  localparam int unsigned ARB_MODE_RR    = 1;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection: descending scan from a start index with wrap.
// Fixed priority is the same scan always starting at N-1.
module prio_pick
  import prio_arb_pkg::*;
#(
  parameter  int unsigned N           = 4,
  parameter  int unsigned ROUND_ROBIN = ARB_MODE_FIXED,
  localparam int unsigned IDXW        = $clog2(N)
) (
  input  logic [N-1:0]    cand,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] win_idx,
  output logic [N-1:0]    win_oh
);

  logic [IDXW-1:0] start_c;

  assign start_c = (ROUND_ROBIN == ARB_MODE_RR) ? ptr : IDXW'(N - 1);

  // First set candidate found scanning downward from start_c wins.
  always_comb begin
    logic [IDXW-1:0] pos;
    any     = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IDXW'((32'(start_c) + N - k) % N);
      if (!any && cand[pos]) begin
        any     = 1'b1;
        win_idx = pos;
      end
    end
    if (any) begin
      win_oh[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/priority_arbiter_n.sv
// Registered N-way arbiter: fixed or round-robin priority, grant held until
// release (done, owner drop, or optional hold timeout), back-to-back handover.
module priority_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter  int unsigned N           = 4,
  parameter  int unsigned ROUND_ROBIN = ARB_MODE_FIXED,
  parameter  int unsigned MAX_HOLD    = 0,
  localparam int unsigned IDXW        = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid
);

  // Counter only needs to reach MAX_HOLD; with no limit a 1-bit saturating count suffices.
  localparam int unsigned HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
  localparam int unsigned HCW      = $clog2(HOLD_SAT + 1);

  arb_state_t      state;
  logic [IDXW-1:0] ptr;
  logic [HCW-1:0]  hold_cnt;

  logic            timeout_c;
  logic            release_c;
  logic [N-1:0]    cand_c;
  logic            any_c;
  logic [IDXW-1:0] win_idx_c;
  logic [N-1:0]    win_oh_c;
  logic [IDXW-1:0] ptr_next_c;

  assign timeout_c  = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD));
  assign release_c  = done || !req[gnt_idx] || timeout_c;
  // The current owner never re-wins on its own release cycle.
  assign cand_c     = (state == ARB_GRANT) ? (req & ~gnt) : req;
  assign ptr_next_c = (win_idx_c == '0) ? IDXW'(N - 1) : (win_idx_c - IDXW'(1));

  prio_pick #(
    .N           (N),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .cand    (cand_c),
    .ptr     (ptr),
    .any     (any_c),
    .win_idx (win_idx_c),
    .win_oh  (win_oh_c)
  );

  // Arbitration FSM with registered grant outputs, rotation pointer and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= IDXW'(N - 1);
      hold_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_c) begin
            state     <= ARB_GRANT;
            gnt       <= win_oh_c;
            gnt_idx   <= win_idx_c;
            gnt_valid <= 1'b1;
            ptr       <= ptr_next_c;
            hold_cnt  <= HCW'(1);
          end
        end
        ARB_GRANT: begin
          if (release_c) begin
            if (any_c) begin
              gnt       <= win_oh_c;
              gnt_idx   <= win_idx_c;
              ptr       <= ptr_next_c;
              hold_cnt  <= HCW'(1);
            end else begin
              state     <= ARB_IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
              hold_cnt  <= '0;
            end
          end else if (hold_cnt != HCW'(HOLD_SAT)) begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        default: begin
          state     <= ARB_IDLE;
          gnt       <= '0;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Bench for priority_arbiter_n: three configurations (fixed, round-robin,
// fixed with MAX_HOLD=3) share one stimulus stream and are each compared
// every cycle against an owner/pointer reference model.
module tb_priority_arbiter_n;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;

  logic [3:0] d_gnt [3];
  logic [1:0] d_idx [3];
  logic       d_vld [3];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance: owner index (-1 = none), rotation pointer, grant-cycle count.
  int m_owner [3];
  int m_ptr   [3];
  int m_hold  [3];
  int m_rr    [3] = '{0, 1, 0};
  int m_mh    [3] = '{0, 0, 3};

  // 4-bit combinational priority circuit: highest set bit wins.
  logic [3:0] prio_tbl [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010,
                                4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                4'b1000, 4'b1000, 4'b1000, 4'b1000};

  priority_arbiter_n #(.N(4), .ROUND_ROBIN(0), .MAX_HOLD(0)) u_fix (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(d_gnt[0]), .gnt_idx(d_idx[0]), .gnt_valid(d_vld[0]));

  priority_arbiter_n #(.N(4), .ROUND_ROBIN(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(d_gnt[1]), .gnt_idx(d_idx[1]), .gnt_valid(d_vld[1]));

  priority_arbiter_n #(.N(4), .ROUND_ROBIN(0), .MAX_HOLD(3)) u_hold (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(d_gnt[2]), .gnt_idx(d_idx[2]), .gnt_valid(d_vld[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] cand, input bit rr, input int ptr);
    int start;
    int i;
    start = rr ? ptr : 3;
    for (int k = 0; k < 4; k++) begin
      i = (start - k + 4) % 4;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_owner[j] = -1;
      m_ptr[j]   = 3;
      m_hold[j]  = 0;
    end
  endtask

  // Advance every model by one clock edge using the current req/done.
  task automatic model_step();
    logic [3:0] cand;
    int         w;
    bit         rel;
    for (int j = 0; j < 3; j++) begin
      if (m_owner[j] < 0) begin
        cand = req;
      end else begin
        rel = done || !req[m_owner[j]] || (m_mh[j] != 0 && m_hold[j] == m_mh[j]);
        if (!rel) begin
          m_hold[j]++;
          continue;
        end
        cand = req;
        cand[m_owner[j]] = 1'b0;
      end
      w = pick(cand, m_rr[j] != 0, m_ptr[j]);
      if (w < 0) begin
        m_owner[j] = -1;
        m_hold[j]  = 0;
      end else begin
        m_owner[j] = w;
        m_ptr[j]   = (w == 0) ? 3 : w - 1;
        m_hold[j]  = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    for (int j = 0; j < 3; j++) begin
      eg = (m_owner[j] < 0) ? 4'b0000 : 4'(1 << m_owner[j]);
      check($sformatf("gnt[%0d]", j), 32'(d_gnt[j]), 32'(eg));
      check($sformatf("idx[%0d]", j), 32'(d_idx[j]), (m_owner[j] < 0) ? 32'd0 : 32'(m_owner[j]));
      check($sformatf("vld[%0d]", j), 32'(d_vld[j]), (m_owner[j] < 0) ? 32'd0 : 32'd1);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Reset pulse between edges; outputs must clear before the next rising edge.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Fixed priority grant, hold, then handover with no idle gap.
    req = 4'b0101;
    step();
    check("t1_gnt", 32'(d_gnt[0]), 32'h4);
    check("t1_idx", 32'(d_idx[0]), 32'd2);
    repeat (3) begin
      step();
      check("t1_hold", 32'(d_gnt[0]), 32'h4);
    end
    done = 1'b1;
    step();
    check("t1_next_gnt", 32'(d_gnt[0]), 32'h1);
    check("t1_next_vld", 32'(d_vld[0]), 32'd1);
    done = 1'b0;
    req  = 4'b0000;
    step();
    step();

    // Round-robin rotation with done every grant cycle.
    mid_reset();
    req  = 4'b1111;
    done = 1'b1;
    step();
    check("t2_rr0", 32'(d_gnt[1]), 32'h8);
    step();
    check("t2_rr1", 32'(d_gnt[1]), 32'h4);
    step();
    check("t2_rr2", 32'(d_gnt[1]), 32'h2);
    step();
    check("t2_rr3", 32'(d_gnt[1]), 32'h1);
    step();
    check("t2_rr4", 32'(d_gnt[1]), 32'h8);
    done = 1'b0;
    req  = 4'b0000;
    step();

    // Hold timeout: three grant cycles then one idle cycle, repeating.
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t3_to%0d", i), 32'(d_gnt[2]), (i % 4 == 3) ? 32'h0 : 32'h2);
    end
    req = 4'b0000;
    step();

    // Owner drops its request: handover, then idle.
    req = 4'b1001;
    step();
    check("t4_own", 32'(d_gnt[0]), 32'h8);
    req = 4'b0001;
    step();
    check("t4_drop", 32'(d_gnt[0]), 32'h1);
    req = 4'b0000;
    step();
    check("t4_idle_gnt", 32'(d_gnt[0]), 32'h0);
    check("t4_idle_vld", 32'(d_vld[0]), 32'd0);

    // Reset mid-grant, then round-robin restarts from the top.
    req = 4'b0100;
    step();
    check("t5_pre", 32'(d_gnt[1]), 32'h4);
    mid_reset();
    check("t5_rst_gnt", 32'(d_gnt[1]), 32'h0);
    check("t5_rst_idx", 32'(d_idx[1]), 32'd0);
    check("t5_rst_vld", 32'(d_vld[1]), 32'd0);
    req = 4'b0011;
    step();
    check("t5_rr", 32'(d_gnt[1]), 32'h2);

    // All 16 request patterns from idle against the priority-circuit table.
    for (int v = 0; v < 16; v++) begin
      req = 4'b0000;
      step();
      req = 4'(v);
      step();
      check($sformatf("t6_sweep%0d", v), 32'(d_gnt[0]), 32'(prio_tbl[v]));
    end

    // Random traffic: sticky requests, random done, occasional mid-grant reset.
    req  = 4'b0000;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        mid_reset();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
